multicycle_control: RTL and testbench
=====================================

Name: multicycle_control

Overview:
- Multi-cycle sequencer for the RV32 subset datapath (R-type, addi, lw, sw, beq).
- Walks each instruction through FETCH/DECODE/EXEC/MEM/WB and drives the shared ALU, register file, PC/IR enables and the instruction/data memory request strobes.
- Memory accesses use a ready handshake with a watchdog; an unknown opcode or an expired watchdog parks the core in TRAP.

Parameters:
- TIMEOUT_CYCLES, 16: maximum number of wait cycles on any memory access before trapping.
- CNT_W, 5: width of the wait counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, synchronous, active-high.
- start_i  in  1  leave IDLE and begin fetching.
- opcode_i  in  7  IR[6:0]; valid from the cycle after ir_write_o.
- zero_i  in  1  ALU zero flag, sampled in EXEC for branches.
- imem_ready_i  in  1  instruction word valid this cycle.
- dmem_ready_i  in  1  data access completes this cycle.
- imem_req_o  out  1  instruction fetch request.
- ir_write_o  out  1  load IR from instruction memory.
- pc_write_o  out  1  update PC.
- pc_src_o  out  1  0 = PC+4, 1 = branch target.
- dmem_read_o  out  1  data memory read request.
- dmem_write_o  out  1  data memory write request.
- alu_op_o  out  2  10 R-type, 11 addi, 00 lw/sw, 01 beq.
- alu_src_o  out  1  1 = immediate operand B.
- reg_write_o  out  1  register file write enable.
- mem_to_reg_o  out  1  1 = writeback data comes from memory.
- retire_o  out  1  one-cycle pulse when an instruction completes.
- illegal_o  out  1  sticky; set when TRAP is entered.
- state_o  out  3  current state encoding.

Behaviour:
- State encodings: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, TRAP=6.
- All outputs are Moore-decoded from the state register and the latched opcode register op_q. They are combinational from registers only, except pc_write_o, ir_write_o and retire_o, which are also gated by the named inputs below.
- Reset: state=IDLE, op_q=0, wait counter=0, illegal_o=0. All outputs are 0 and state_o=0. Reset asserted mid-instruction aborts it; no write strobe is asserted in the reset cycle or the cycle after.
- IDLE: start_i=1 moves to FETCH; otherwise stay.
- FETCH:
  - imem_req_o=1.
  - If imem_ready_i=1: ir_write_o=1, pc_write_o=1, pc_src_o=0, next state DECODE.
  - Otherwise the counter increments; when it reaches TIMEOUT_CYCLES, go to TRAP.
- DECODE:
  - op_q <= opcode_i.
  - Legal opcodes (0110011, 0010011, 0000011, 0100011, 1100011) go to EXEC; any other opcode goes to TRAP.
- EXEC:
  - alu_op_o and alu_src_o are driven per op_q; alu_src_o=1 for addi, lw and sw.
  - R-type and addi go to WB.
  - lw and sw go to MEM.
  - beq: pc_write_o=zero_i, pc_src_o=1, retire_o=1, next state FETCH.
- MEM:
  - lw drives dmem_read_o=1; sw drives dmem_write_o=1. The strobe is held until dmem_ready_i.
  - When dmem_ready_i=1: lw goes to WB; sw pulses retire_o and goes to FETCH.
  - Watchdog behaves as in FETCH.
- WB:
  - reg_write_o=1 and retire_o=1.
  - mem_to_reg_o=1 only for lw.
  - Next state FETCH.
- TRAP:
  - All strobes are 0 and illegal_o=1.
  - The state is held until rst_i; start_i is ignored.
- Wait counter: clears on every state change. It saturates and never wraps.
- A ready signal arriving in the same cycle the counter hits the limit wins: the access completes and no trap is taken.
- Latency with zero wait states: R-type/addi 4 cycles, lw 5, sw 4, beq 3. Each wait cycle adds 1.
- Ready inputs are ignored outside their consuming state.
- start_i is ignored outside IDLE.

Test Plan:
1. Reset, start_i pulse, ready inputs tied high, opcode 0110011 -> state sequence 1,2,3,5,1; reg_write_o high in cycle 4 only, alu_op_o=10, retire_o pulses once.
2. lw (0000011) with dmem_ready_i delayed 3 cycles -> dmem_read_o held 4 cycles, then WB with mem_to_reg_o=1; total 8 cycles.
3. beq with zero_i=1 and then zero_i=0 -> pc_write_o with pc_src_o=1 asserted in EXEC only for the first; both retire in 3 cycles.
4. opcode 1111111 -> TRAP in the cycle after DECODE, illegal_o=1, no reg_write_o/dmem strobes; a later start_i has no effect.
5. imem_ready_i held low -> TRAP after exactly 16 wait cycles; in a second run, ready asserted on the 16th wait cycle -> DECODE, no trap.
6. rst_i asserted during MEM of sw -> state=0 next cycle, dmem_write_o=0; restart executes cleanly.

Source files
------------

// File: rtl/multicycle_control.sv
// Multi-cycle control sequencer for an RV32 subset (R-type, addi, lw, sw, beq).
// Each instruction moves through FETCH/DECODE/EXEC/MEM/WB. The outputs drive the
// shared ALU, the register file, the PC/IR enables and the memory request strobes.
// A watchdog bounds every memory wait. An unknown opcode or an expired watchdog
// parks the core in TRAP until reset.
module multicycle_control #(
   parameter int TIMEOUT_CYCLES = 16,
   parameter int CNT_W          = 5
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       start_i,
   input  logic [6:0] opcode_i,
   input  logic       zero_i,
   input  logic       imem_ready_i,
   input  logic       dmem_ready_i,
   output logic       imem_req_o,
   output logic       ir_write_o,
   output logic       pc_write_o,
   output logic       pc_src_o,
   output logic       dmem_read_o,
   output logic       dmem_write_o,
   output logic [1:0] alu_op_o,
   output logic       alu_src_o,
   output logic       reg_write_o,
   output logic       mem_to_reg_o,
   output logic       retire_o,
   output logic       illegal_o,
   output logic [2:0] state_o
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_MEM    = 3'd4,
      S_WB     = 3'd5,
      S_TRAP   = 3'd6
   } state_t;

   localparam logic [6:0] OP_R    = 7'b0110011;
   localparam logic [6:0] OP_ADDI = 7'b0010011;
   localparam logic [6:0] OP_LW   = 7'b0000011;
   localparam logic [6:0] OP_SW   = 7'b0100011;
   localparam logic [6:0] OP_BEQ  = 7'b1100011;

   // Value held by the counter on the last wait cycle that may still end in a
   // timeout; a ready seen in that same cycle still completes the access.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

   state_t           state_q, state_d;
   logic [6:0]       op_q, op_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             illegal_q, illegal_d;
   logic             wait_s;

   logic             imem_req_s, ir_write_s, pc_write_s, pc_src_s;
   logic             dmem_read_s, dmem_write_s, alu_src_s;
   logic             reg_write_s, mem_to_reg_s, retire_s;
   logic [1:0]       alu_op_s;

   function automatic logic is_legal(input logic [6:0] op);
      logic ok;
      case (op)
         OP_R, OP_ADDI, OP_LW, OP_SW, OP_BEQ: ok = 1'b1;
         default:                             ok = 1'b0;
      endcase
      return ok;
   endfunction

   // Next-state, opcode latch, wait counter and sticky trap flag
   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      wait_s  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start_i) state_d = S_FETCH;
            else         state_d = S_IDLE;
         end
         S_FETCH: begin
            if (imem_ready_i) begin
               state_d = S_DECODE;
            end else begin
               wait_s = 1'b1;
               if (cnt_q >= CNT_LAST) state_d = S_TRAP;
               else                   state_d = S_FETCH;
            end
         end
         S_DECODE: begin
            op_d = opcode_i;
            if (is_legal(opcode_i)) state_d = S_EXEC;
            else                    state_d = S_TRAP;
         end
         S_EXEC: begin
            case (op_q)
               OP_R, OP_ADDI: state_d = S_WB;
               OP_LW, OP_SW:  state_d = S_MEM;
               OP_BEQ:        state_d = S_FETCH;
               default:       state_d = S_TRAP;
            endcase
         end
         S_MEM: begin
            if (dmem_ready_i) begin
               if (op_q == OP_LW)      state_d = S_WB;
               else if (op_q == OP_SW) state_d = S_FETCH;
               else                    state_d = S_TRAP;
            end else begin
               wait_s = 1'b1;
               if (cnt_q >= CNT_LAST) state_d = S_TRAP;
               else                   state_d = S_MEM;
            end
         end
         S_WB:    state_d = S_FETCH;
         S_TRAP:  state_d = S_TRAP;
         default: state_d = S_TRAP;
      endcase

      // Counter restarts on every state change and saturates while waiting
      if (state_d != state_q)                cnt_d = {CNT_W{1'b0}};
      else if (wait_s && (cnt_q != CNT_MAX)) cnt_d = cnt_q + CNT_W'(1);
      else                                   cnt_d = cnt_q;

      illegal_d = illegal_q | (state_d == S_TRAP);
   end

   // State, opcode, counter and trap flag registers with synchronous reset
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= S_IDLE;
         op_q      <= 7'b0000000;
         cnt_q     <= {CNT_W{1'b0}};
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         cnt_q     <= cnt_d;
         illegal_q <= illegal_d;
      end
   end

   // Moore output decode from state and latched opcode; only the named strobes look at ready/zero
   always_comb begin
      imem_req_s   = 1'b0;
      ir_write_s   = 1'b0;
      pc_write_s   = 1'b0;
      pc_src_s     = 1'b0;
      dmem_read_s  = 1'b0;
      dmem_write_s = 1'b0;
      alu_op_s     = 2'b00;
      alu_src_s    = 1'b0;
      reg_write_s  = 1'b0;
      mem_to_reg_s = 1'b0;
      retire_s     = 1'b0;
      case (state_q)
         S_FETCH: begin
            imem_req_s = 1'b1;
            ir_write_s = imem_ready_i;
            pc_write_s = imem_ready_i;
         end
         S_EXEC: begin
            case (op_q)
               OP_R: begin
                  alu_op_s = 2'b10;
               end
               OP_ADDI: begin
                  alu_op_s  = 2'b11;
                  alu_src_s = 1'b1;
               end
               OP_LW, OP_SW: begin
                  alu_op_s  = 2'b00;
                  alu_src_s = 1'b1;
               end
               OP_BEQ: begin
                  alu_op_s   = 2'b01;
                  pc_src_s   = 1'b1;
                  pc_write_s = zero_i;
                  retire_s   = 1'b1;
               end
               default: begin
                  alu_op_s = 2'b00;
               end
            endcase
         end
         S_MEM: begin
            if (op_q == OP_LW) begin
               dmem_read_s = 1'b1;
            end else if (op_q == OP_SW) begin
               dmem_write_s = 1'b1;
               retire_s     = dmem_ready_i;
            end else begin
               dmem_read_s = 1'b0;
            end
         end
         S_WB: begin
            reg_write_s  = 1'b1;
            retire_s     = 1'b1;
            mem_to_reg_s = (op_q == OP_LW);
         end
         default: begin
            imem_req_s = 1'b0;
         end
      endcase
   end

   // A reset cycle aborts the instruction in flight, so every strobe is forced low while rst_i is high
   assign imem_req_o   = imem_req_s   & ~rst_i;
   assign ir_write_o   = ir_write_s   & ~rst_i;
   assign pc_write_o   = pc_write_s   & ~rst_i;
   assign pc_src_o     = pc_src_s     & ~rst_i;
   assign dmem_read_o  = dmem_read_s  & ~rst_i;
   assign dmem_write_o = dmem_write_s & ~rst_i;
   assign alu_op_o     = alu_op_s     & {2{~rst_i}};
   assign alu_src_o    = alu_src_s    & ~rst_i;
   assign reg_write_o  = reg_write_s  & ~rst_i;
   assign mem_to_reg_o = mem_to_reg_s & ~rst_i;
   assign retire_o     = retire_s     & ~rst_i;
   assign illegal_o    = illegal_q;
   assign state_o      = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed testbench for multicycle_control. Each task drives one scenario
// cycle by cycle and compares the full output vector against hand-derived values.
module tb_multicycle_control;

   logic       clk = 1'b0;
   logic       rst_i = 1'b1;
   logic       start_i = 1'b0;
   logic [6:0] opcode_i = 7'b0000000;
   logic       zero_i = 1'b0;
   logic       imem_ready_i = 1'b0;
   logic       dmem_ready_i = 1'b0;
   logic       imem_req_o, ir_write_o, pc_write_o, pc_src_o;
   logic       dmem_read_o, dmem_write_o, alu_src_o;
   logic       reg_write_o, mem_to_reg_o, retire_o, illegal_o;
   logic [1:0] alu_op_o;
   logic [2:0] state_o;

   int passed = 0;
   int total  = 0;

   localparam logic [6:0] OP_R    = 7'b0110011;
   localparam logic [6:0] OP_ADDI = 7'b0010011;
   localparam logic [6:0] OP_LW   = 7'b0000011;
   localparam logic [6:0] OP_SW   = 7'b0100011;
   localparam logic [6:0] OP_BEQ  = 7'b1100011;
   localparam logic [6:0] OP_BAD  = 7'b1111111;

   // Flag order: imem_req ir_write pc_write pc_src dmem_read dmem_write alu_op[1:0] alu_src reg_write mem_to_reg retire illegal
   localparam logic [12:0] F_NONE       = 13'b0_0_0_0_0_0_00_0_0_0_0_0;
   localparam logic [12:0] F_FETCH_OK   = 13'b1_1_1_0_0_0_00_0_0_0_0_0;
   localparam logic [12:0] F_FETCH_WAIT = 13'b1_0_0_0_0_0_00_0_0_0_0_0;
   localparam logic [12:0] F_EX_R       = 13'b0_0_0_0_0_0_10_0_0_0_0_0;
   localparam logic [12:0] F_EX_ADDI    = 13'b0_0_0_0_0_0_11_1_0_0_0_0;
   localparam logic [12:0] F_EX_MEM     = 13'b0_0_0_0_0_0_00_1_0_0_0_0;
   localparam logic [12:0] F_EX_BEQ_T   = 13'b0_0_1_1_0_0_01_0_0_0_1_0;
   localparam logic [12:0] F_EX_BEQ_N   = 13'b0_0_0_1_0_0_01_0_0_0_1_0;
   localparam logic [12:0] F_RD         = 13'b0_0_0_0_1_0_00_0_0_0_0_0;
   localparam logic [12:0] F_WR_WAIT    = 13'b0_0_0_0_0_1_00_0_0_0_0_0;
   localparam logic [12:0] F_WR_DONE    = 13'b0_0_0_0_0_1_00_0_0_0_1_0;
   localparam logic [12:0] F_WB_ALU     = 13'b0_0_0_0_0_0_00_0_1_0_1_0;
   localparam logic [12:0] F_WB_LD      = 13'b0_0_0_0_0_0_00_0_1_1_1_0;
   localparam logic [12:0] F_TRAP       = 13'b0_0_0_0_0_0_00_0_0_0_0_1;

   logic [15:0] obs_s;
   assign obs_s = {state_o, imem_req_o, ir_write_o, pc_write_o, pc_src_o, dmem_read_o,
                   dmem_write_o, alu_op_o, alu_src_o, reg_write_o, mem_to_reg_o,
                   retire_o, illegal_o};

   multicycle_control #(.TIMEOUT_CYCLES(16), .CNT_W(5)) dut (
      .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .opcode_i(opcode_i),
      .zero_i(zero_i), .imem_ready_i(imem_ready_i), .dmem_ready_i(dmem_ready_i),
      .imem_req_o(imem_req_o), .ir_write_o(ir_write_o), .pc_write_o(pc_write_o),
      .pc_src_o(pc_src_o), .dmem_read_o(dmem_read_o), .dmem_write_o(dmem_write_o),
      .alu_op_o(alu_op_o), .alu_src_o(alu_src_o), .reg_write_o(reg_write_o),
      .mem_to_reg_o(mem_to_reg_o), .retire_o(retire_o), .illegal_o(illegal_o),
      .state_o(state_o)
   );

   always #5 clk = ~clk;

   // One reset cycle; returns 1 time unit after the edge that cleared the state
   task automatic do_reset();
      rst_i   = 1'b1;
      start_i = 1'b0;
      @(posedge clk); #1;
      rst_i = 1'b0;
   endtask

   task automatic test_reset();
      rst_i = 1'b1; start_i = 1'b1; opcode_i = OP_BAD;
      imem_ready_i = 1'b1; dmem_ready_i = 1'b1; zero_i = 1'b1;
      @(posedge clk); @(posedge clk); #1;
      total++;
      if (obs_s !== {3'd0, F_NONE}) $display("FAIL reset_held: got %b want %b", obs_s, {3'd0, F_NONE});
      else passed++;
      rst_i = 1'b0; start_i = 1'b0;
      for (int i = 0; i < 2; i++) begin
         #1;
         total++;
         if (obs_s !== {3'd0, F_NONE}) $display("FAIL reset_idle c%0d: got %b want %b", i, obs_s, {3'd0, F_NONE});
         else passed++;
         @(posedge clk); #1;
      end
   endtask

   task automatic test_rtype();
      logic [15:0] exp_v [0:5];
      int retires;
      exp_v = '{{3'd0, F_NONE}, {3'd1, F_FETCH_OK}, {3'd2, F_NONE},
                {3'd3, F_EX_R}, {3'd5, F_WB_ALU}, {3'd1, F_FETCH_OK}};
      do_reset();
      opcode_i = OP_R; imem_ready_i = 1'b1; dmem_ready_i = 1'b1; zero_i = 1'b0;
      retires = 0;
      for (int i = 0; i < 6; i++) begin
         start_i = (i == 0);
         #1;
         total++;
         if (obs_s !== exp_v[i]) $display("FAIL rtype c%0d: got %b want %b", i, obs_s, exp_v[i]);
         else passed++;
         if (i >= 1 && i <= 4 && retire_o === 1'b1) retires++;
         @(posedge clk); #1;
      end
      total++;
      if (retires !== 1) $display("FAIL rtype_retire_count: got %0d want 1", retires);
      else passed++;
   endtask

   task automatic test_lw_wait();
      logic [15:0] exp_v [0:9];
      exp_v = '{{3'd0, F_NONE}, {3'd1, F_FETCH_OK}, {3'd2, F_NONE}, {3'd3, F_EX_MEM},
                {3'd4, F_RD}, {3'd4, F_RD}, {3'd4, F_RD}, {3'd4, F_RD},
                {3'd5, F_WB_LD}, {3'd1, F_FETCH_OK}};
      do_reset();
      opcode_i = OP_LW; imem_ready_i = 1'b1;
      for (int i = 0; i < 10; i++) begin
         start_i = (i == 0);
         dmem_ready_i = (i <= 3) || (i == 7);
         #1;
         total++;
         if (obs_s !== exp_v[i]) $display("FAIL lw_wait c%0d: got %b want %b", i, obs_s, exp_v[i]);
         else passed++;
         @(posedge clk); #1;
      end
   endtask

   task automatic test_beq();
      logic [15:0] exp_v [0:7];
      exp_v = '{{3'd0, F_NONE}, {3'd1, F_FETCH_OK}, {3'd2, F_NONE}, {3'd3, F_EX_BEQ_T},
                {3'd1, F_FETCH_OK}, {3'd2, F_NONE}, {3'd3, F_EX_BEQ_N}, {3'd1, F_FETCH_OK}};
      do_reset();
      opcode_i = OP_BEQ; imem_ready_i = 1'b1; dmem_ready_i = 1'b1;
      for (int i = 0; i < 8; i++) begin
         start_i = (i == 0);
         zero_i  = (i < 5);
         #1;
         total++;
         if (obs_s !== exp_v[i]) $display("FAIL beq c%0d: got %b want %b", i, obs_s, exp_v[i]);
         else passed++;
         @(posedge clk); #1;
      end
   endtask

   task automatic test_illegal();
      logic [15:0] exp_v [0:5];
      exp_v = '{{3'd0, F_NONE}, {3'd1, F_FETCH_OK}, {3'd2, F_NONE},
                {3'd6, F_TRAP}, {3'd6, F_TRAP}, {3'd6, F_TRAP}};
      do_reset();
      opcode_i = OP_BAD; imem_ready_i = 1'b1; dmem_ready_i = 1'b1; zero_i = 1'b0;
      for (int i = 0; i < 6; i++) begin
         start_i = (i == 0) || (i == 4);
         #1;
         total++;
         if (obs_s !== exp_v[i]) $display("FAIL illegal c%0d: got %b want %b", i, obs_s, exp_v[i]);
         else passed++;
         @(posedge clk); #1;
      end
   endtask

   task automatic test_fetch_timeout();
      logic [15:0] exp_e;
      do_reset();
      opcode_i = OP_ADDI; imem_ready_i = 1'b0; dmem_ready_i = 1'b0;
      for (int i = 0; i < 18; i++) begin
         start_i = (i == 0);
         if (i == 0)       exp_e = {3'd0, F_NONE};
         else if (i <= 16) exp_e = {3'd1, F_FETCH_WAIT};
         else              exp_e = {3'd6, F_TRAP};
         #1;
         total++;
         if (obs_s !== exp_e) $display("FAIL timeout c%0d: got %b want %b", i, obs_s, exp_e);
         else passed++;
         @(posedge clk); #1;
      end
      // Ready on the 16th wait cycle must beat the watchdog
      do_reset();
      for (int i = 0; i < 20; i++) begin
         start_i = (i == 0);
         imem_ready_i = (i == 16);
         if (i == 0)       exp_e = {3'd0, F_NONE};
         else if (i <= 15) exp_e = {3'd1, F_FETCH_WAIT};
         else if (i == 16) exp_e = {3'd1, F_FETCH_OK};
         else if (i == 17) exp_e = {3'd2, F_NONE};
         else if (i == 18) exp_e = {3'd3, F_EX_ADDI};
         else              exp_e = {3'd5, F_WB_ALU};
         #1;
         total++;
         if (obs_s !== exp_e) $display("FAIL timeout_edge c%0d: got %b want %b", i, obs_s, exp_e);
         else passed++;
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset_mid_sw();
      logic [15:0] exp_v [0:12];
      exp_v = '{{3'd0, F_NONE}, {3'd1, F_FETCH_OK}, {3'd2, F_NONE}, {3'd3, F_EX_MEM},
                {3'd4, F_WR_WAIT}, {3'd4, F_NONE}, {3'd0, F_NONE}, {3'd0, F_NONE},
                {3'd1, F_FETCH_OK}, {3'd2, F_NONE}, {3'd3, F_EX_MEM},
                {3'd4, F_WR_DONE}, {3'd1, F_FETCH_OK}};
      do_reset();
      opcode_i = OP_SW; imem_ready_i = 1'b1; zero_i = 1'b0;
      for (int i = 0; i < 13; i++) begin
         start_i      = (i == 0) || (i == 7);
         rst_i        = (i == 5);
         dmem_ready_i = (i == 11);
         #1;
         total++;
         if (obs_s !== exp_v[i]) $display("FAIL reset_mid_sw c%0d: got %b want %b", i, obs_s, exp_v[i]);
         else passed++;
         @(posedge clk); #1;
      end
   endtask

   // Main sequence
   initial begin
      test_reset();
      test_rtype();
      test_lw_wait();
      test_beq();
      test_illegal();
      test_fetch_timeout();
      test_reset_mid_sw();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   // Runaway guard
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, passed=%0d total=%0d", passed, total);
      $fatal(1);
   end

endmodule
